pz_frame_assembler: RTL



---
 rtl/pz_pkg.sv | 19 +
 rtl/pz_byte_timeout.sv | 30 +++
 rtl/pz_frame_assembler.sv | 115 +++++++++++
 3 files changed

// File: rtl/pz_pkg.sv
// Shared constants and state encoding for the pole/zero frame assembler.
package pz_pkg;

  localparam int N_ZEROS       = 4;
  localparam int N_POLES       = 4;
  localparam int COEF_W        = 32;
  localparam int PAYLOAD_BYTES = 32;
  localparam int STAGE_W       = PAYLOAD_BYTES * 8;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    COMMIT  = 2'd3
  } pz_state_t;

endpackage

// File: rtl/pz_byte_timeout.sv
// Idle-cycle counter between accepted bytes; flags expiry on the last allowed idle cycle.
module pz_byte_timeout #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TW             = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TW'(1);
    end
  end

  // Expiry coincides with the idle cycle that would bring the count to TIMEOUT_CYCLES.
  assign expired = enable && !clear && (count == LIMIT);

endmodule

// File: rtl/pz_frame_assembler.sv
// Parses sync/payload/checksum byte frames into 4 zeros and 4 poles for the downstream latch.
module pz_frame_assembler
  import pz_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         TW             = 17
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [N_ZEROS*COEF_W-1:0]   zero_out,
  output logic [N_POLES*COEF_W-1:0]   pole_out,
  output logic                        frame_done,
  output logic                        err_pulse,
  output logic [7:0]                  err_count
);

  pz_state_t          state;
  logic [4:0]         byte_idx;
  logic [STAGE_W-1:0] staging;
  logic [7:0]         checksum;

  logic transfer;
  logic active;
  logic tmo_expired;
  logic err_event;

  assign transfer  = in_valid && in_ready;
  assign active    = (state == PAYLOAD) || (state == CHECK);
  assign err_event = tmo_expired || ((state == CHECK) && transfer && (in_data != checksum));

  pz_byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TW            (TW)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (!active || transfer),
    .enable (active && !transfer),
    .expired(tmo_expired)
  );

  // Coefficient outputs move only in COMMIT, so a bad or aborted frame never disturbs them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      byte_idx   <= '0;
      staging    <= '0;
      checksum   <= '0;
      in_ready   <= 1'b1;
      zero_out   <= '0;
      pole_out   <= '0;
      frame_done <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
    end else begin
      frame_done <= 1'b0;
      err_pulse  <= err_event;
      if (err_event && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end

      case (state)
        HUNT: begin
          if (transfer && (in_data == SYNC_BYTE)) begin
            state    <= PAYLOAD;
            byte_idx <= '0;
            checksum <= '0;
          end
        end
        PAYLOAD: begin
          if (tmo_expired) begin
            state <= HUNT;
          end else if (transfer) begin
            staging  <= {staging[STAGE_W-9:0], in_data};
            checksum <= checksum ^ in_data;
            byte_idx <= byte_idx + 5'd1;
            if (byte_idx == 5'(PAYLOAD_BYTES - 1)) begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (tmo_expired) begin
            state <= HUNT;
          end else if (transfer) begin
            if (in_data == checksum) begin
              state    <= COMMIT;
              in_ready <= 1'b0;
            end else begin
              state <= HUNT;
            end
          end
        end
        COMMIT: begin
          // First payload byte sits at the top of staging: zero0 MSB first, pole3 last.
          for (int i = 0; i < N_ZEROS; i++) begin
            zero_out[COEF_W*i +: COEF_W] <= staging[STAGE_W-1-COEF_W*i -: COEF_W];
          end
          for (int i = 0; i < N_POLES; i++) begin
            pole_out[COEF_W*i +: COEF_W] <= staging[(N_POLES-i)*COEF_W-1 -: COEF_W];
          end
          frame_done <= 1'b1;
          in_ready   <= 1'b1;
          state      <= HUNT;
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule
